// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: extends an IN_W-bit immediate by mode and
// buffers results in a 2-entry in-order queue behind a valid/ready handshake.
module imm_ext_pipe #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    // Returns {ovf, result}; ovf flags mode 3 results that no longer round-trip.
    function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
        logic signed [IN_W-1:0]  imm_s;
        logic signed [OUT_W-1:0] sext;
        logic signed [OUT_W-1:0] shl;
        logic        [OUT_W-1:0] zext;
        logic        [OUT_W-1:0] res;
        logic                    ovf;
        imm_s = imm;
        sext  = OUT_W'(imm_s);
        zext  = OUT_W'(imm);
        shl   = sext <<< SHIFT;
        res   = sext;
        ovf   = 1'b0;
        case (mode)
            2'b00: begin
                res = sext;
                ovf = 1'b0;
            end
            2'b01: begin
                res = zext;
                ovf = 1'b0;
            end
            2'b10: begin
                res = zext << (OUT_W - IN_W);
                ovf = 1'b0;
            end
            2'b11: begin
                res = shl;
                ovf = ((shl >>> SHIFT) != sext);
            end
            default: begin
                res = sext;
                ovf = 1'b0;
            end
        endcase
        return {ovf, res};
    endfunction

    logic [OUT_W-1:0] mem_data_q [2];
    logic [OUT_W-1:0] mem_data_d [2];
    logic             mem_ovf_q  [2];
    logic             mem_ovf_d  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W:0]   ext_s;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Next-state for queue storage, pointers, count and the registered head view.
    always_comb begin
        ext_s       = extend(in_imm, in_mode);
        push_s      = in_valid & in_ready;
        pop_s       = out_valid_q & out_ready;
        mem_data_d  = mem_data_q;
        mem_ovf_d   = mem_ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (push_s) begin
            mem_data_d[wr_ptr_q] = ext_s[OUT_W-1:0];
            mem_ovf_d[wr_ptr_q]  = ext_s[OUT_W];
            wr_ptr_d             = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // When the queue drains, the head view keeps the last popped value.
        out_valid_d = (count_d != 2'd0);
        if (count_d != 2'd0) begin
            out_data_d = mem_data_d[rd_ptr_d];
            out_ovf_d  = mem_ovf_d[rd_ptr_d];
        end else begin
            out_data_d = out_data_q;
            out_ovf_d  = out_ovf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_data_q[0] <= {OUT_W{1'b0}};
            mem_data_q[1] <= {OUT_W{1'b0}};
            mem_ovf_q[0]  <= 1'b0;
            mem_ovf_q[1]  <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            out_data_q    <= {OUT_W{1'b0}};
            out_ovf_q     <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            mem_data_q    <= mem_data_d;
            mem_ovf_q     <= mem_ovf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_data_q    <= out_data_d;
            out_ovf_q     <= out_ovf_d;
            out_valid_q   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: a default instance and a SHIFT=16 instance
// share one stimulus stream; a negedge monitor checks each against its own queue.
module tb_imm_ext_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [16:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [31:0] out_data0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [31:0] out_data1;

    logic [32:0] exp0[$];
    logic [32:0] exp1[$];
    int          checks = 0;
    int          fails  = 0;
    logic        mon_en = 1'b0;

    always #5 clock = ~clock;

    imm_ext_pipe #(.IN_W(17), .OUT_W(32), .SHIFT(2)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ovf(out_ovf0)
    );

    imm_ext_pipe #(.IN_W(17), .OUT_W(32), .SHIFT(16)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ovf(out_ovf1)
    );

    // Reference: treat the immediate as an integer and apply each mode arithmetically.
    function automatic logic [32:0] model(input logic [16:0] imm, input logic [1:0] mode,
                                          input int shift);
        longint u, s, v;
        logic [31:0] r;
        logic        ovf;
        u   = longint'(imm);
        s   = imm[16] ? (u - 64'sd131072) : u;
        ovf = 1'b0;
        v   = s;
        case (mode)
            2'd0: v = s;
            2'd1: v = u;
            2'd2: v = u * 64'sd32768;
            2'd3: begin
                v   = s * (64'sd1 <<< shift);
                ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
            end
            default: v = s;
        endcase
        r = v[31:0];
        return {ovf, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Monitor: check flow control and head entry, then retire/record this cycle's handshakes.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("in_ready0", 64'(in_ready0), 64'(exp0.size() != 2));
            chk("out_valid0", 64'(out_valid0), 64'(exp0.size() != 0));
            chk("in_ready1", 64'(in_ready1), 64'(exp1.size() != 2));
            chk("out_valid1", 64'(out_valid1), 64'(exp1.size() != 0));
            if (out_valid0 && exp0.size() != 0)
                chk("head0", 64'({out_ovf0, out_data0}), 64'(exp0[0]));
            if (out_valid1 && exp1.size() != 0)
                chk("head1", 64'({out_ovf1, out_data1}), 64'(exp1[0]));
            if (!reset_n) begin
                exp0.delete();
                exp1.delete();
            end else begin
                if (out_valid0 && out_ready && exp0.size() != 0) void'(exp0.pop_front());
                if (out_valid1 && out_ready && exp1.size() != 0) void'(exp1.pop_front());
                if (in_valid && in_ready0) exp0.push_back(model(in_imm, in_mode, 2));
                if (in_valid && in_ready1) exp1.push_back(model(in_imm, in_mode, 16));
            end
        end
    end

    task automatic push_see(input logic [16:0] imm, input logic [1:0] mode,
                            input logic [32:0] w0, input logic [32:0] w1);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        cyc();
        chk("lat_valid0", 64'(out_valid0), 64'd1);
        chk("lat_data0", 64'({out_ovf0, out_data0}), 64'(w0));
        chk("lat_data1", 64'({out_ovf1, out_data1}), 64'(w1));
    endtask

    initial begin
        logic accepted;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_imm    = 17'd0;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        chk("rst_valid", 64'({out_valid0, out_valid1}), 64'd0);
        chk("rst_data", 64'({out_data0, out_data1}), 64'd0);
        chk("rst_ovf", 64'({out_ovf0, out_ovf1}), 64'd0);
        chk("rst_ready", 64'({in_ready0, in_ready1}), 64'd3);
        mon_en = 1'b1;

        // Directed modes, one per cycle with the consumer always ready.
        out_ready = 1'b1;
        push_see(17'h10000, 2'd0, {1'b0, 32'hFFFF0000}, {1'b0, 32'hFFFF0000});
        push_see(17'h1FFFF, 2'd1, {1'b0, 32'h0001FFFF}, {1'b0, 32'h0001FFFF});
        push_see(17'h00001, 2'd2, {1'b0, 32'h00008000}, {1'b0, 32'h00008000});
        push_see(17'h1FFFF, 2'd3, {1'b0, 32'hFFFFFFFC}, {1'b0, 32'hFFFF0000});
        push_see(17'h0FFFF, 2'd3, {1'b0, 32'h0003FFFC}, {1'b1, 32'hFFFF0000});
        push_see(17'h00001, 2'd3, {1'b0, 32'h00000004}, {1'b0, 32'h00010000});
        in_valid = 1'b0;
        cyc();

        // Backpressure: A and B fill the queue, C must be held until space frees.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_imm    = 17'h0000A; cyc();
        in_imm    = 17'h0000B; cyc();
        in_imm    = 17'h0000C; cyc();
        chk("full_ready", 64'(in_ready0), 64'd0);
        cyc();
        chk("full_hold", 64'({out_ovf0, out_data0}), 64'h0000A);
        out_ready = 1'b1;
        accepted  = 1'b0;
        for (int k = 0; k < 6 && !accepted; k++) begin
            accepted = in_ready0;
            cyc();
        end
        chk("c_accepted", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        repeat (3) cyc();

        // Simultaneous push/pop at count 1.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 17'h00100;
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_imm = 17'(17'h00101 + i);
            cyc();
            chk("pp_ready", 64'(in_ready0), 64'd1);
            chk("pp_head", 64'(out_data0), 64'(17'h00101 + i));
        end
        in_valid = 1'b0;
        repeat (2) cyc();

        // Reset with a full queue, then the next push must be the first result.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_imm    = 17'h00011; cyc();
        in_imm    = 17'h00022; cyc();
        chk("pre_rst_full", 64'(in_ready0), 64'd0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("mid_rst_valid", 64'({out_valid0, out_valid1}), 64'd0);
        chk("mid_rst_data", 64'({out_data0, out_data1}), 64'd0);
        chk("mid_rst_ovf", 64'({out_ovf0, out_ovf1}), 64'd0);
        chk("mid_rst_ready", 64'({in_ready0, in_ready1}), 64'd3);
        out_ready = 1'b1;
        push_see(17'h00033, 2'd0, {1'b0, 32'h00000033}, {1'b0, 32'h00000033});
        in_valid = 1'b0;
        cyc();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_imm    = 17'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("drained0", 64'(exp0.size()), 64'd0);
        chk("drained1", 64'(exp1.size()), 64'd0);
        mon_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
